// File: rtl/vh_pkg.sv
// Shared constants and field-layout helpers for the vloghammer result unpacker.
// Field k is 4 + (k mod 3) bits wide and is signed when (k mod 6) >= 3.
package vh_pkg;

    localparam int VH_NFIELDS = 18;
    localparam int VH_YW      = 90;
    localparam int VH_OW      = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [2:0] vh_fwidth(input logic [4:0] k);
        vh_fwidth = 3'd4 + 3'(k % 5'd3);
    endfunction

    function automatic logic vh_fsigned(input logic [4:0] k);
        vh_fsigned = ((k % 5'd6) >= 5'd3);
    endfunction

endpackage

// File: rtl/vh_result_unpacker_if.sv
// Packed-vector input and per-field output handshake bundle of the unpacker.
interface vh_result_unpacker_if;
    import vh_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [VH_YW-1:0]    in_y;
    logic                out_valid;
    logic                out_ready;
    logic [4:0]          out_idx;
    logic [VH_OW-1:0]    out_field;
    logic                out_signed;
    logic                out_last;
    logic [VH_OW-1:0]    out_chk;

    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_idx, out_field, out_signed, out_last, out_chk
    );

    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_idx, out_field, out_signed, out_last, out_chk
    );

endinterface

// File: rtl/vh_field_ext.sv
// Extends the current field, held in the top bits of a 6-bit window, to 8 bits.
module vh_field_ext (
    input  logic [5:0] top6,
    input  logic [2:0] width,
    input  logic       sgn,
    output logic [7:0] field
);

    logic [7:0] raw_s;
    logic [7:0] mask_s;

    // Right-align the field, then fill the bits above it with its sign when signed.
    always_comb begin
        raw_s  = {2'b00, top6} >> (3'd6 - width);
        mask_s = 8'hFF << width;
        if (sgn && top6[5]) begin
            field = raw_s | mask_s;
        end else begin
            field = raw_s;
        end
    end

endmodule

// File: rtl/vh_result_unpacker.sv
// Accepts one packed 90-bit result vector and streams its 18 fields out one
// per handshake, extended to 8 bits, with a running XOR checksum on the last.
module vh_result_unpacker
    import vh_pkg::*;
#(
    parameter int NFIELDS = VH_NFIELDS,
    parameter int YW      = VH_YW,
    parameter int OW      = VH_OW
) (
    input  logic                 clk,
    input  logic                 reset,
    vh_result_unpacker_if.slave  bus
);

    state_t          state_q, state_d;
    logic [4:0]      idx_q,   idx_d;
    logic [YW-1:0]   sr_q,    sr_d;
    logic [OW-1:0]   chk_q,   chk_d;

    logic [2:0]      fw_s;
    logic            fsgn_s;
    logic [OW-1:0]   ext_s;
    logic            emit_s;
    logic            last_s;
    logic            out_hs_s;

    assign fw_s     = vh_fwidth(idx_q);
    assign fsgn_s   = vh_fsigned(idx_q);
    assign emit_s   = (state_q == ST_EMIT);
    assign last_s   = emit_s && (idx_q == 5'(NFIELDS - 1));
    assign out_hs_s = emit_s && bus.out_ready;

    vh_field_ext u_ext (
        .top6  (sr_q[YW-1 -: 6]),
        .width (fw_s),
        .sgn   (fsgn_s),
        .field (ext_s)
    );

    // Outputs are decoded straight from registered state; only in_ready and
    // out_chk reach through to out_ready / the live field.
    assign bus.in_ready   = !reset && (!emit_s || (last_s && bus.out_ready));
    assign bus.out_valid  = emit_s;
    assign bus.out_idx    = idx_q;
    assign bus.out_field  = emit_s ? ext_s : {OW{1'b0}};
    assign bus.out_signed = emit_s && fsgn_s;
    assign bus.out_last   = last_s;
    assign bus.out_chk    = last_s ? (chk_q ^ ext_s) : {OW{1'b0}};

    // Next-state logic: load a vector, shift out one field per handshake, and
    // chain the next vector on the final handshake when one is waiting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        chk_d   = chk_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = bus.in_y;
                    idx_d   = 5'd0;
                    chk_d   = {OW{1'b0}};
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_hs_s) begin
                    chk_d = chk_q ^ ext_s;
                    sr_d  = sr_q << fw_s;
                    if (last_s) begin
                        if (bus.in_valid) begin
                            sr_d    = bus.in_y;
                            idx_d   = 5'd0;
                            chk_d   = {OW{1'b0}};
                            state_d = ST_EMIT;
                        end else begin
                            idx_d   = 5'd0;
                            chk_d   = {OW{1'b0}};
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
                sr_d    = {YW{1'b0}};
                chk_d   = {OW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            sr_q    <= {YW{1'b0}};
            chk_q   <= {OW{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: doc/vh_result_unpacker.md
# vh_result_unpacker

Receive-side companion to the vloghammer expression blocks. It accepts one packed 90-bit result vector `y` from a DUT over a valid/ready port. It then streams the 18 constituent fields `y0`..`y17` out one per handshake, each extended to 8 bits according to its declared signedness, and reports a running XOR checksum with the last field. It sits between the expression DUT and the regression scoreboard, so the scoreboard compares fields individually instead of re-slicing the bus.

## Interface
Parameters:
- `NFIELDS`, 18: fields per vector.
- `YW`, 90: packed vector width.
- `OW`, 8: output field width after extension.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  packed vector valid.
- `in_ready`  out  1  unpacker can accept a vector.
- `in_y`  in  90  packed vector; `y0` in bits [89:86].
- `out_valid`  out  1  field valid.
- `out_ready`  in  1  consumer accepts field.
- `out_idx`  out  5  field index 0..17.
- `out_field`  out  8  field, sign- or zero-extended.
- `out_signed`  out  1  field k is signed.
- `out_last`  out  1  high with field 17.
- `out_chk`  out  8  XOR of all extended fields of the vector; valid only with `out_last`, 0 otherwise.

## Operation
Field layout:
- Field k width is `4 + (k mod 3)`.
- Field k is signed iff `(k mod 6) >= 3`.
- Fields are packed MSB-first with no gaps; group of 3 = 15 bits.
- Offsets: f0 [89:86], f1 [85:81], f2 [80:75], f3 [74:71], … f17 [5:0].

Datapath:
- 90-bit shift register `sr`.
- Current field = top `w(k)` bits of `sr`.
- Extension: signed fields replicate their MSB up to 8 bits; unsigned fields zero-fill.

State machine, two states:
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: load `sr`←`in_y`, idx←0, chk←0, go EMIT.
- EMIT:
  - `out_valid`=1.
  - On `out_ready`: chk←chk^`out_field`, `sr`←`sr`<<`w(idx)`.
  - If idx<17: idx++.
  - If idx==17: go IDLE.
  - Exception: if `in_valid` is also high in that same cycle, load the new vector and stay in EMIT.

Handshake rules:
- `in_ready` = IDLE or (EMIT, idx==17, `out_ready`); combinational from `out_ready`.
- While `out_valid` and not `out_ready`: `out_idx`, `out_field`, `out_last`, `out_chk` hold stable.
- `out_chk` = chk_reg ^ `out_field` when `out_last`, else 0. It is combinational, so it includes field 17.
- `in_y` is sampled only on the `in_valid`&&`in_ready` edge; later changes are ignored.

## Timing
- Reset:
  - state IDLE, idx 0, `sr` 0, chk 0.
  - `out_valid` 0, `out_idx` 0, `out_field` 0, `out_signed` 0, `out_last` 0, `out_chk` 0.
  - `in_ready` is forced 0 while `reset` is high and is 1 in the first cycle after.
- Latency: field 0 is presented the cycle after input acceptance.
- Throughput: 18 cycles per vector with `out_ready` held high. Back-to-back vectors have no bubble.
- Reset mid-EMIT: the partial vector is discarded. The next cycle matches reset values; no `out_last` is emitted for the dropped vector.
- `in_valid` in EMIT before the final handshake: not accepted, since `in_ready`=0. The producer must hold `in_valid` and `in_y`.
- `out_ready` high in IDLE: no effect.

## Structure
Shared package `vh_pkg`:
- `VH_NFIELDS`, `VH_YW`, `VH_OW`.
- Function `vh_fwidth(k)` returning 4/5/6.
- Function `vh_fsigned(k)`.

Sub-module `vh_field_ext`: combinational; takes the top 6 bits of `sr`, width and signed flag, and produces the 8-bit extended field. The FSM, counter, shift register and checksum live in the top module.

## Test plan
- `in_y`=0, `out_ready`=1:
  - 18 fields, all 0x00.
  - `out_idx` 0..17, `out_last` only at idx 17, `out_chk`=0x00.
- `in_y`=all ones:
  - Unsigned fields give 0x0F/0x1F/0x3F; signed fields give 0xFF.
  - `out_signed` set for idx 3–5, 9–11, 15–17.
  - `out_chk`=0xD0.
- `in_y`=1<<89 → f0=0x08, others 0. `in_y`=1<<74 → f3=0xF8, others 0.
- `out_ready` low for 5 cycles while idx=7: idx, field and `out_valid` held; no skip or duplicate after release.
- Two vectors, `in_valid` continuously high, `out_ready`=1:
  - 36 consecutive field handshakes with no gap.
  - Second vector accepted in the same cycle as the first vector's idx 17.
- `reset` pulse at idx 10:
  - Next cycle `out_valid`=0, `out_idx`=0, `out_chk`=0; `in_ready`=1 the cycle after reset deasserts.
  - A new vector then starts at idx 0.
